// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requests feeding a 2-entry {pc, instr} FIFO.
// Optional performance counters are enabled by defining INSTR_FETCH_PERF_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [5:0]  op_o,
    output logic [31:0] pc_o
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        req_q;
    logic [31:0] addr_q;

    logic [31:0] fifo_pc_q  [2];
    logic [31:0] fifo_ins_q [2];
    logic [31:0] fifo_pc_d  [2];
    logic [31:0] fifo_ins_d [2];
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic [1:0]  cnt_pop;

    logic        pop;
    logic        ack_ok;
    logic        push;
    logic        slot_ok;
    logic [31:0] redirect_pc;
    logic [31:0] ack_next_pc;

    // Acks only count while a request is actually outstanding, so stray strobes are ignored.
    assign ack_ok      = req_q && imem_ack_i;
    assign pop         = (count_q != 2'd0) && instr_ready_i;
    assign push        = ack_ok && (state_q == FETCH) && !branch_i;
    assign cnt_pop     = count_q - {1'b0, pop};
    assign slot_ok     = !count_d[1];
    assign redirect_pc = branch_i ? branch_addr_i : pc_q;
    assign ack_next_pc = branch_i ? branch_addr_i : (addr_q + 32'd4);

    always_comb begin
        fifo_pc_d  = fifo_pc_q;
        fifo_ins_d = fifo_ins_q;
        count_d    = count_q;
        if (branch_i) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                fifo_pc_d[0]  = fifo_pc_q[1];
                fifo_ins_d[0] = fifo_ins_q[1];
            end
            if (push) begin
                fifo_pc_d[cnt_pop[0]]  = addr_q;
                fifo_ins_d[cnt_pop[0]] = imem_data_i;
            end
            count_d = cnt_pop + {1'b0, push};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_pc_q[i]  <= '0;
                fifo_ins_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            fifo_pc_q  <= fifo_pc_d;
            fifo_ins_q <= fifo_ins_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    pc_q <= redirect_pc;
                    if (start_i && slot_ok) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        addr_q  <= redirect_pc;
                    end
                end
                FETCH: begin
                    if (ack_ok) begin
                        pc_q <= ack_next_pc;
                        if (start_i && slot_ok) begin
                            addr_q <= ack_next_pc;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end else if (branch_i) begin
                        state_q <= DRAIN;
                        pc_q    <= branch_addr_i;
                    end
                end
                DRAIN: begin
                    // Request and address stay up until the stale response arrives.
                    pc_q <= redirect_pc;
                    if (ack_ok) begin
                        if (start_i) begin
                            state_q <= FETCH;
                            addr_q  <= redirect_pc;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = (count_q != 2'd0);
    assign instr_o       = fifo_ins_q[0];
    assign op_o          = fifo_ins_q[0][31:26];
    assign pc_o          = fifo_pc_q[0];

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop && !branch_i) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (branch_i) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic against a queue-level model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        branch;
    logic [31:0] baddr;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [31:0] w_pc;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned wcnt  = 0;

    always #5 clk = ~clk;

    instr_fetch u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_data_i(data),
        .branch_i(branch), .branch_addr_i(baddr),
        .instr_valid_o(valid), .instr_ready_i(ready),
        .instr_o(instr), .op_o(op), .pc_o(pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_ack_i(ack), .imem_data_i(data),
        .branch_i(branch), .branch_addr_i(baddr),
        .instr_valid_o(w_valid), .instr_ready_i(ready),
        .instr_o(w_instr), .op_o(w_op), .pc_o(w_pc)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b0; start = 1'b0; ready = 1'b0; branch = 1'b0;
        baddr = '0; ack = 1'b0; data = '0; wcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Memory responder: ack once the current request has waited lat cycles.
    task automatic mem_step(input int unsigned lat);
        if (req) begin
            if (wcnt >= lat) begin
                ack = 1'b1; data = memf(addr); wcnt = 0;
            end else begin
                ack = 1'b0; data = '0; wcnt++;
            end
        end else begin
            ack = 1'b0; data = '0; wcnt = 0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; ready = 1'b0; branch = 1'b0;
        baddr = '0; ack = 1'b0; data = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", req); end
        n_cmp++; if (addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", addr); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", instr); end
        n_cmp++; if (op !== 6'h0) begin n_err++; $display("FAIL reset_op got %h want 0", op); end
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", pc); end
        n_cmp++; if (w_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL reset_addr_param got %h want fffffffc", w_addr); end
    endtask

    task automatic test_sequential;
        int unsigned got;
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
        got = 0;
        apply_reset();
        start = 1'b1; ready = 1'b1;
        for (int c = 0; c < 80 && got < 4; c++) begin
            mem_step(1);
            if (valid && ready) begin
                exp_pc  = 32'd4 * got;
                exp_ins = memf(exp_pc);
                n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL seq_pc[%0d] got %h want %h", got, pc, exp_pc); end
                n_cmp++; if (op !== exp_ins[31:26]) begin n_err++; $display("FAIL seq_op[%0d] got %h want %h", got, op, exp_ins[31:26]); end
                n_cmp++; if (instr !== exp_ins) begin n_err++; $display("FAIL seq_instr[%0d] got %h want %h", got, instr, exp_ins); end
                got++;
            end
            tick();
        end
        n_cmp++; if (got != 4) begin n_err++; $display("FAIL seq_timeout got %0d handoffs want 4", got); end
    endtask

    task automatic test_backpressure;
        int unsigned acks;
        acks = 0;
        apply_reset();
        start = 1'b1; ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            mem_step(0);
            if (ack && req) acks++;
            tick();
        end
        ack = 1'b0;
        n_cmp++; if (acks != 2) begin n_err++; $display("FAIL bp_accepted got %0d want 2", acks); end
        n_cmp++; if (req !== 1'b0) begin n_err++; $display("FAIL bp_req_full got %b want 0", req); end
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %b want 1", valid); end
        ready = 1'b1;
        mem_step(0);
        if (ack && req) acks++;
        tick();
        ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            mem_step(0);
            if (ack && req) acks++;
            tick();
        end
        ack = 1'b0;
        n_cmp++; if (acks != 3) begin n_err++; $display("FAIL bp_refill got %0d want 3", acks); end
        n_cmp++; if (req !== 1'b0) begin n_err++; $display("FAIL bp_req_after got %b want 0", req); end
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL bp_head_pc got %h want 4", pc); end
    endtask

    task automatic test_branch_pending;
        logic seen_valid;
        seen_valid = 1'b0;
        apply_reset();
        start = 1'b1; ready = 1'b0;
        tick();
        n_cmp++; if (req !== 1'b1 || addr !== 32'h0) begin n_err++; $display("FAIL brp_first_req got %b/%h want 1/0", req, addr); end
        branch = 1'b1; baddr = 32'h100;
        tick();
        branch = 1'b0; baddr = '0;
        for (int c = 0; c < 2; c++) begin
            if (valid) seen_valid = 1'b1;
            tick();
        end
        ack = 1'b1; data = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0; data = '0;
        if (valid) seen_valid = 1'b1;
        n_cmp++; if (seen_valid !== 1'b0) begin n_err++; $display("FAIL brp_discard got valid=%b want 0", seen_valid); end
        n_cmp++; if (req !== 1'b1 || addr !== 32'h100) begin n_err++; $display("FAIL brp_target got %b/%h want 1/100", req, addr); end
        ack = 1'b1; data = memf(32'h100);
        tick();
        ack = 1'b0;
        n_cmp++; if (valid !== 1'b1 || pc !== 32'h100) begin n_err++; $display("FAIL brp_head got %b/%h want 1/100", valid, pc); end
        n_cmp++; if (instr !== memf(32'h100)) begin n_err++; $display("FAIL brp_instr got %h want %h", instr, memf(32'h100)); end
    endtask

    task automatic test_branch_full;
        apply_reset();
        start = 1'b1; ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            mem_step(0);
            tick();
        end
        ack = 1'b0;
        n_cmp++; if (valid !== 1'b1 || req !== 1'b0) begin n_err++; $display("FAIL brf_full got %b/%b want 1/0", valid, req); end
        ready = 1'b1;
        tick();
        ack = 1'b1; data = memf(addr); ready = 1'b1; branch = 1'b1; baddr = 32'h200;
        tick();
        ack = 1'b0; ready = 1'b0; branch = 1'b0; baddr = '0;
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL brf_flush got %b want 0", valid); end
        n_cmp++; if (req !== 1'b1 || addr !== 32'h200) begin n_err++; $display("FAIL brf_target got %b/%h want 1/200", req, addr); end
    endtask

    task automatic test_wrap;
        logic first_ok;
        apply_reset();
        start = 1'b1; ready = 1'b1;
        tick();
        first_ok = w_req && (w_addr == 32'hFFFF_FFFC);
        n_cmp++; if (first_ok !== 1'b1) begin n_err++; $display("FAIL wrap_first got %b/%h want 1/fffffffc", w_req, w_addr); end
        ack = 1'b1; data = memf(w_addr);
        tick();
        ack = 1'b0;
        n_cmp++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin n_err++; $display("FAIL wrap_second got %b/%h want 1/0", w_req, w_addr); end
        n_cmp++; if (w_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_head_pc got %h want fffffffc", w_pc); end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        start = 1'b1;
        tick();
        n_cmp++; if (req !== 1'b1) begin n_err++; $display("FAIL rmid_req got %b want 1", req); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (req !== 1'b0 || addr !== 32'h0) begin n_err++; $display("FAIL rmid_async got %b/%h want 0/0", req, addr); end
        start = 1'b0;
        tick();
        rst = 1'b1; ack = 1'b1; data = 32'hFFFF_FFFF; ready = 1'b1;
        tick();
        tick();
        ack = 1'b0; data = '0; ready = 1'b0;
        n_cmp++; if (valid !== 1'b0 || req !== 1'b0) begin n_err++; $display("FAIL rmid_stray got %b/%b want 0/0", valid, req); end
        n_cmp++; if (instr !== 32'h0 || op !== 6'h0 || pc !== 32'h0 || addr !== 32'h0) begin
            n_err++; $display("FAIL rmid_outs got %h/%h/%h/%h want zeros", instr, op, pc, addr);
        end
    endtask

    // Model: handed-off pcs run sequentially from the last redirect; responses to requests
    // that were outstanding when a branch arrived never reach the queue.
    task automatic test_random;
        int unsigned occ;
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
        logic        tainted;
        logic        prev_pending;
        logic [31:0] prev_addr;
        logic        handoff;
        logic        acked;
        occ = 0; exp_pc = 32'h0; tainted = 1'b0; prev_pending = 1'b0; prev_addr = '0;
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            n_cmp++; if (valid !== (occ != 0)) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, valid, occ != 0); end
            if (prev_pending) begin
                n_cmp++; if (req !== 1'b1 || addr !== prev_addr) begin
                    n_err++; $display("FAIL rnd_stable cyc %0d got %b/%h want 1/%h", c, req, addr, prev_addr);
                end
            end
            start  = ($urandom % 8) != 0;
            ready  = $urandom % 2;
            branch = ($urandom % 16) == 0;
            baddr  = $urandom & 32'hFFFF_FFFC;
            ack    = req && ($urandom % 2);
            data   = ack ? memf(addr) : $urandom;
            handoff = valid && ready && !branch;
            if (handoff) begin
                exp_ins = memf(exp_pc);
                n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc cyc %0d got %h want %h", c, pc, exp_pc); end
                n_cmp++; if (instr !== exp_ins) begin n_err++; $display("FAIL rnd_instr cyc %0d got %h want %h", c, instr, exp_ins); end
                n_cmp++; if (op !== exp_ins[31:26]) begin n_err++; $display("FAIL rnd_op cyc %0d got %h want %h", c, op, exp_ins[31:26]); end
                exp_pc = exp_pc + 32'd4;
            end
            acked = req && ack;
            if (branch) begin
                occ = 0;
                exp_pc = baddr;
                if (req && !ack) tainted = 1'b1;
            end else begin
                if (handoff) occ--;
                if (acked && !tainted) occ++;
            end
            if (acked) tainted = 1'b0;
            n_cmp++; if (occ > 2) begin n_err++; $display("FAIL rnd_overflow cyc %0d got %0d entries want <=2", c, occ); end
            prev_pending = req && !ack;
            prev_addr    = addr;
            tick();
        end
        ack = 1'b0; branch = 1'b0; start = 1'b0; ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ready = 1'b0; branch = 1'b0;
        baddr = '0; ack = 1'b0; data = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_pending();
        test_branch_full();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
